// File: rtl/mutex_seq_pkg.sv
// Shared types and default constants for the two-client mutex request sequencer.
package mutex_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    REL  = 2'd3
  } cl_state_e;

  typedef logic [1:0] client_idx_t;

  localparam int unsigned DEF_HOLD_CYCLES    = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
  localparam int unsigned DEF_CNT_W          = 8;

endpackage

// File: rtl/mutex_client_fsm.sv
// Per-client IDLE/REQ/HOLD/REL sequencer; start-to-req 1 cycle, own held HOLD_CYCLES cycles.
// Optional grant-wait timeout under MUTEX_SEQ_TIMEOUT_EN; start is dropped while not IDLE.
module mutex_client_fsm
  import mutex_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
`ifdef MUTEX_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic gs,
  output logic req,
  output logic busy,
  output logic own,
  output logic done,
  output logic timeout
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  cl_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             done_q, done_d;

`ifdef MUTEX_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef MUTEX_SEQ_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef MUTEX_SEQ_TIMEOUT_EN
        wcnt_d = '0;
`endif
        if (start) state_d = REQ;
      end
      REQ: begin
        // A grant arriving in the last wait cycle still wins over the timeout.
        if (gs) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
`ifdef MUTEX_SEQ_TIMEOUT_EN
        else if (wcnt_q == WAIT_LAST) begin
          state_d   = REL;
          timeout_d = 1'b1;
        end else if (wcnt_q != '1) begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
`endif
      end
      HOLD: begin
        if (cnt_q == '0) state_d = REL;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      REL: begin
        if (!gs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ) || (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef MUTEX_SEQ_TIMEOUT_EN
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      done_q  <= done_d;
`ifdef MUTEX_SEQ_TIMEOUT_EN
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign req  = req_q;
  assign busy = (state_q != IDLE);
  assign own  = (state_q == HOLD);
  assign done = done_q;
`ifdef MUTEX_SEQ_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/mutex_client_seq.sv
// Two-client request sequencer in front of a 2-way mutex; grant-to-own 3 edges, sticky error flags.
// Optional grant-wait timeout under MUTEX_SEQ_TIMEOUT_EN; no backpressure, extra starts are dropped.
module mutex_client_seq
  import mutex_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] start,
  input  logic [1:0] grant,
  output logic [1:0] req,
  output logic [1:0] busy,
  output logic [1:0] own,
  output logic [1:0] done,
  output logic [1:0] timeout,
  output logic       err_excl,
  output logic       err_spur
);

  client_idx_t gs_meta_q, gs_meta_d;
  client_idx_t gs_q, gs_d;
  logic        err_excl_q, err_excl_d;
  logic        err_spur_q, err_spur_d;

  // Grants come from the mutex's own timing domain; two flops per bit before use.
  always_comb begin
    gs_meta_d  = grant;
    gs_d       = gs_meta_q;
    err_excl_d = err_excl_q | (&gs_q);
    err_spur_d = err_spur_q | (|(gs_q & ~busy));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gs_meta_q  <= '0;
      gs_q       <= '0;
      err_excl_q <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      gs_meta_q  <= gs_meta_d;
      gs_q       <= gs_d;
      err_excl_q <= err_excl_d;
      err_spur_q <= err_spur_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_client
    mutex_client_fsm #(
      .HOLD_CYCLES    (HOLD_CYCLES),
      .CNT_W          (CNT_W)
`ifdef MUTEX_SEQ_TIMEOUT_EN
      , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_fsm (
      .clk     (clk),
      .rst     (rst),
      .start   (start[i]),
      .gs      (gs_q[i]),
      .req     (req[i]),
      .busy    (busy[i]),
      .own     (own[i]),
      .done    (done[i]),
      .timeout (timeout[i])
    );
  end

  assign err_excl = err_excl_q;
  assign err_spur = err_spur_q;

endmodule

// File: tb/tb_mutex_client_seq.sv
// Randomized scoreboard bench for mutex_client_seq with a behavioural mutex and client model.
module tb_mutex_client_seq;

  localparam int HOLD = 4;
  localparam int TMO  = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [1:0] start = 2'b00;
  logic [1:0] grant = 2'b00;
  logic [1:0] req, busy, own, done, timeout;
  logic       err_excl, err_spur;

  mutex_client_seq #(
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .grant    (grant),
    .req      (req),
    .busy     (busy),
    .own      (own),
    .done     (done),
    .timeout  (timeout),
    .err_excl (err_excl),
    .err_spur (err_spur)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int req_cyc;
    bit exp_to;
  } tx_t;

  tx_t exp_q [2][$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit       mutex_en = 1'b1;
  bit       force11  = 1'b0;
  int       owner    = -1;
  bit [1:0] g1 = 2'b00, g2 = 2'b00;
  bit       exp_excl = 1'b0, exp_spur = 1'b0;
  bit       req_prev [2];
  int       req_rise [2];
  int       own_len  [2];
  bit       to_seen  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor, reference model and behavioural mutex, all evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      g1 = 2'b00; g2 = 2'b00; exp_excl = 1'b0; exp_spur = 1'b0;
    end else begin
      if (g2 == 2'b11) exp_excl = 1'b1;
      for (int i = 0; i < 2; i++)
        if (g2[i] && exp_q[i].size() == 0) exp_spur = 1'b1;
      g2 = g1;
      g1 = grant;
    end

    if (rst) begin
      check("rst_req",  req,  0);
      check("rst_own",  own,  0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_tmo",  timeout, 0);
      for (int i = 0; i < 2; i++) begin
        exp_q[i].delete();
        req_prev[i] = 1'b0; own_len[i] = 0; to_seen[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        tx_t h;
        if (req[i] && !req_prev[i]) begin
          check("req_pending", exp_q[i].size(), 1);
          if (exp_q[i].size() > 0) begin
            h = exp_q[i][0];
            check("req_latency", cyc, h.req_cyc);
          end
          req_rise[i] = cyc;
        end
        if (own[i]) own_len[i]++;
        if (timeout[i]) begin
          check("tmo_pending", exp_q[i].size(), 1);
          if (exp_q[i].size() > 0) begin
            h = exp_q[i][0];
            check("tmo_expected", timeout[i], h.exp_to);
            check("tmo_latency", cyc - req_rise[i], TMO);
          end
          to_seen[i] = 1'b1;
        end
        if (done[i]) begin
          check("done_pending", exp_q[i].size(), 1);
          if (exp_q[i].size() > 0) begin
            h = exp_q[i].pop_front();
            check("own_len", own_len[i], h.exp_to ? 0 : HOLD);
            check("tmo_seen", to_seen[i], h.exp_to);
          end
          own_len[i] = 0;
          to_seen[i] = 1'b0;
        end
        req_prev[i] = req[i];
      end
`ifndef MUTEX_SEQ_TIMEOUT_EN
      check("tmo_tied", timeout, 0);
`endif
    end
    check("own_excl", (own == 2'b11), 0);
    check("err_excl", err_excl, exp_excl);
    check("err_spur", err_spur, exp_spur);

    if (!mutex_en) begin
      owner = -1;
      grant = 2'b00;
    end else if (force11) begin
      grant = 2'b11;
    end else begin
      if (owner >= 0 && !req[owner]) owner = -1;
      if (owner < 0) begin
        if (req == 2'b11)  owner = int'($urandom_range(0, 1));
        else if (req[0])   owner = 0;
        else if (req[1])   owner = 1;
      end
      grant = (owner < 0) ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] s, input bit to);
    for (int i = 0; i < 2; i++) begin
      if (s[i] && exp_q[i].size() == 0) begin
        tx_t t;
        t.req_cyc = cyc + 1;
        t.exp_to  = to;
        exp_q[i].push_back(t);
      end
    end
    start = s;
    tick();
    start = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    pulse(2'b01, 1'b0);
    repeat (20) tick();

`ifndef MUTEX_SEQ_TIMEOUT_EN
    pulse(2'b11, 1'b0);
    repeat (30) tick();
`endif

    // Second start lands while client 0 is in HOLD and must be ignored.
    pulse(2'b01, 1'b0);
    repeat (4) tick();
    pulse(2'b01, 1'b0);
    repeat (20) tick();

    for (int n = 0; n < 400; n++) begin
      logic [1:0] s;
      s = 2'b00;
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 3) == 0) s[i] = 1'b1;
`ifdef MUTEX_SEQ_TIMEOUT_EN
      if (exp_q[0].size() + exp_q[1].size() != 0) s = 2'b00;
      if (s == 2'b11) s = 2'b01;
`endif
      pulse(s, 1'b0);
    end
    repeat (40) tick();

    force11 = 1'b1;
    repeat (3) tick();
    force11 = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    pulse(2'b01, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (15) tick();

`ifdef MUTEX_SEQ_TIMEOUT_EN
    mutex_en = 1'b0;
    pulse(2'b10, 1'b1);
    repeat (20) tick();
    mutex_en = 1'b1;
    repeat (5) tick();
`endif

    check("q0_drained", exp_q[0].size(), 0);
    check("q1_drained", exp_q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mutex_client_seq.md
# mutex_client_seq

Two-client request sequencer that sits directly upstream of the two-way mutex arbiter (`Arbiter_2_Mutex`). It turns single-cycle `start` pulses from two clients into level requests on the arbiter's X1/X0 inputs. Each request is held until the corresponding Y1/Y0 grant is observed and the resource has been owned for a fixed tenure. The block then releases the request, waits for the grant to drop, and signals `done`. It also flags mutual-exclusion violations seen on the grant lines.

## Interface
- `HOLD_CYCLES`, 4: cycles a client owns the resource once granted; legal range 1..2^CNT_W-1.
- `TIMEOUT_CYCLES`, 64: maximum cycles spent waiting for a grant; used only with the timeout feature.
- `CNT_W`, 8: width of the tenure and timeout counters.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  2  per-client start pulse; bit i is client i.
- `grant`  in  2  Y1/Y0 from the mutex; treated as asynchronous.
- `req`  out  2  X1/X0 to the mutex; registered.
- `busy`  out  2  client i is not IDLE.
- `own`  out  2  client i is in HOLD.
- `done`  out  2  one-cycle pulse when client i returns to IDLE.
- `timeout`  out  2  one-cycle pulse when client i abandons its request.
- `err_excl`  out  1  sticky; both synchronized grants were high in the same cycle.
- `err_spur`  out  1  sticky; a synchronized grant was high while that client was in IDLE.

## Operation
- Each `grant` bit passes through its own 2-flop synchronizer; the result is `gs[i]`.
- Each client runs an independent FSM with states IDLE, REQ, HOLD, REL:
  - IDLE: `req`=0. If `start[i]`=1, go to REQ. `start` is ignored in every other state; it is not queued.
  - REQ: `req`=1, `busy`=1. If `gs[i]`=1, go to HOLD and load `cnt`=HOLD_CYCLES-1.
  - HOLD: `req`=1, `own`=1. If `cnt`=0, go to REL; otherwise decrement `cnt`.
  - REL: `req`=0. If `gs[i]`=0, go to IDLE and pulse `done[i]`.
- Simultaneous starts: both clients enter REQ and both `req` bits assert. The mutex decides the order; the loser stays in REQ until the winner's grant drops.
- `err_excl` sets when `gs`=2'b11. `err_spur` sets when `gs[i]`=1 while client i is in IDLE. Both are cleared only by `rst`.
- Counters are unsigned CNT_W bits and never wrap: the decrement is gated at 0.

## Timing
- Reset values: all outputs are 0, all FSMs are in IDLE, counters and synchronizers are 0.
- Reset applied mid-operation drops `req` on the next edge and discards any pending `done`.
- `start[i]` sampled at edge k drives `req[i]`=1 after edge k.
- A grant rising before edge m makes `gs[i]`=1 after edge m+1, and the FSM enters HOLD at edge m+2.
- `own[i]` stays high for exactly HOLD_CYCLES cycles.
- `req[i]` falls on the same edge at which `own[i]` falls.
- `done[i]` is high for the single cycle after the edge at which the FSM leaves REL.
- Start-to-`req` latency is 1 cycle; grant-to-`own` latency is 3 edges.

## Configuration
- `MUTEX_SEQ_TIMEOUT_EN` defined:
  - Each client has a wait counter that counts up in REQ.
  - When the counter reaches TIMEOUT_CYCLES-1 and `gs[i]`=0, the FSM goes to REL and pulses `timeout[i]` for one cycle; `done[i]` still follows.
  - If `gs[i]`=1 in that same cycle, the grant wins and the FSM goes to HOLD.
- `MUTEX_SEQ_TIMEOUT_EN` undefined: REQ waits indefinitely, `timeout` is tied to 0, and the wait counter is not built.

## Structure
- Package `mutex_seq_pkg`: state enum (IDLE, REQ, HOLD, REL), default HOLD/TIMEOUT constants, 2-bit client index type.
- Sub-module `mutex_client_fsm`: per-client FSM with counters, instantiated twice.
- The top level holds the synchronizers and the error flags.

## Test plan
- Reset then `start`=2'b01 for one cycle, with the mutex granting client 0 -> `req`=01 at +1, `own[0]` high for 4 cycles, `done[0]` pulses once, `req` returns to 00.
- `start`=2'b11 in the same cycle -> both `req` bits high, `own` is never 11, each client completes with exactly one `done`, `err_excl`=0.
- `start[0]` pulsed again while client 0 is in HOLD -> no second request and only one `done`.
- Force `grant`=11 for 3 cycles -> `err_excl`=1, and it stays 1 until `rst`.
- Assert `rst` during HOLD -> `req`, `own` and `busy` are 0 after the next edge, no `done` pulse.
- With the macro defined and TIMEOUT_CYCLES=8, grant held at 0 -> `timeout[1]` pulses 8 cycles after REQ entry, followed by `done[1]`; `req[1]` drops.
